retire_trace_buffer: RTL and testbench

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

---
 rtl/retire_trace_buffer.sv | 138 +++++++++++++
 tb/tb_retire_trace_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - retirement trace capture buffer with halt-PC stop and drain port
module retire_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int WRAP  = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       arm,
    input  logic [XLEN-1:0]            halt_pc,
    input  logic                       ret_valid,
    input  logic [XLEN-1:0]            ret_pc,
    input  logic [31:0]                ret_instr,
    input  logic                       ret_we,
    input  logic [4:0]                 ret_rd,
    input  logic [XLEN-1:0]            ret_wdata,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_we,
    output logic [4:0]                 out_rd,
    output logic [XLEN-1:0]            out_wdata,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     entries,
    output logic [31:0]                retired_count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * XLEN + 38;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t         st_q, st_d;
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [31:0]    rcnt_q, rcnt_d;
    logic           ovf_q, ovf_d;
    logic           wr_en;
    logic           full;
    logic [EW-1:0]  wr_entry;
    logic [EW-1:0]  mem [DEPTH];

    assign full     = (cnt_q == FULL_CNT);
    // x0 is never written, so a write to rd=0 is recorded as no write
    assign wr_entry = {ret_pc, ret_instr, ret_we && (ret_rd != 5'd0), ret_rd, ret_wdata};
    assign {out_pc, out_instr, out_we, out_rd, out_wdata} = mem[head_q];
    assign out_valid     = (st_q == S_DRAIN) && (cnt_q != '0);
    assign state         = st_q;
    assign entries       = cnt_q;
    assign retired_count = rcnt_q;
    assign overflow      = ovf_q;

    always_comb begin
        st_d   = st_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        rcnt_d = rcnt_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        case (st_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    head_d = '0;
                    tail_d = '0;
                    cnt_d  = '0;
                    rcnt_d = '0;
                    ovf_d  = 1'b0;
                    st_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (arm) begin
                    head_d = '0;
                    tail_d = '0;
                    cnt_d  = '0;
                    rcnt_d = '0;
                    ovf_d  = 1'b0;
                end else if (ret_valid) begin
                    if (rcnt_q != 32'hffff_ffff) rcnt_d = rcnt_q + 32'd1;
                    if (!full) begin
                        wr_en  = 1'b1;
                        tail_d = tail_q + 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end else if (WRAP != 0) begin
                        // overwrite the oldest slot: tail and head advance together
                        wr_en  = 1'b1;
                        tail_d = tail_q + 1'b1;
                        head_d = head_q + 1'b1;
                        ovf_d  = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                        st_d  = S_DRAIN;
                    end
                    if (ret_pc == halt_pc) st_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    st_d = S_DONE;
                end else if (out_ready) begin
                    head_d = head_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= S_IDLE;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            rcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            rcnt_q <= rcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[tail_q] <= wr_entry;
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - bench for retire_trace_buffer, WRAP=1 (index 0) and WRAP=0 (index 1)
module tb_retire_trace_buffer;
    localparam int DEPTH = 16;
    localparam int EW    = 102;

    logic        clk = 1'b0;
    logic        reset_n, arm, ret_valid, ret_we, out_ready;
    logic [31:0] halt_pc, ret_pc, ret_instr, ret_wdata;
    logic [4:0]  ret_rd;

    logic        ov   [2];
    logic [31:0] opc  [2];
    logic [31:0] oins [2];
    logic        owe  [2];
    logic [4:0]  ord  [2];
    logic [31:0] owd  [2];
    logic [1:0]  ost  [2];
    logic [4:0]  oent [2];
    logic [31:0] orc  [2];
    logic        oovf [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        retire_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .WRAP(g == 0 ? 1 : 0)) u_dut (
            .clk(clk), .reset_n(reset_n), .arm(arm), .halt_pc(halt_pc),
            .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
            .ret_we(ret_we), .ret_rd(ret_rd), .ret_wdata(ret_wdata),
            .out_ready(out_ready), .out_valid(ov[g]), .out_pc(opc[g]),
            .out_instr(oins[g]), .out_we(owe[g]), .out_rd(ord[g]), .out_wdata(owd[g]),
            .state(ost[g]), .entries(oent[g]), .retired_count(orc[g]), .overflow(oovf[g])
        );
    end

    // Reference model: trace kept as a list with the oldest entry at index 0
    logic [EW-1:0] m_buf [2][DEPTH];
    int            m_n   [2];
    int            m_st  [2];
    longint        m_rc  [2];
    logic          m_ovf [2];
    int            n_assert = 0;
    int            n_fail   = 0;

    task automatic m_clear(input int d);
        m_n[d] = 0; m_rc[d] = 0; m_ovf[d] = 1'b0;
    endtask

    task automatic m_pop(input int d);
        for (int i = 0; i < DEPTH - 1; i++) m_buf[d][i] = m_buf[d][i+1];
        m_n[d]--;
    endtask

    task automatic model_edge(input int d);
        logic [EW-1:0] e;
        bit wrap;
        wrap = (d == 0);
        e = {ret_pc, ret_instr, ret_we && (ret_rd != 5'd0), ret_rd, ret_wdata};
        if (!reset_n) begin
            m_clear(d); m_st[d] = 0;
            return;
        end
        case (m_st[d])
            0, 3: if (arm) begin m_clear(d); m_st[d] = 1; end
            1: begin
                if (arm) m_clear(d);
                else if (ret_valid) begin
                    if (m_rc[d] < 64'hffff_ffff) m_rc[d]++;
                    if (m_n[d] < DEPTH) begin
                        m_buf[d][m_n[d]] = e; m_n[d]++;
                    end else begin
                        m_ovf[d] = 1'b1;
                        if (wrap) begin m_pop(d); m_buf[d][DEPTH-1] = e; m_n[d]++; end
                        else m_st[d] = 2;
                    end
                    if (ret_pc == halt_pc) m_st[d] = 2;
                end
            end
            2: if (m_n[d] == 0) m_st[d] = 3; else if (out_ready) m_pop(d);
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] head_bus(input int d);
        return {opc[d], oins[d], owe[d], ord[d], owd[d]};
    endfunction

    task automatic check_dut(input int d);
        bit exp_valid;
        exp_valid = (m_st[d] == 2) && (m_n[d] > 0);
        chk("state", d, 128'(ost[d]), 128'(m_st[d]));
        chk("entries", d, 128'(oent[d]), 128'(m_n[d]));
        chk("retired_count", d, 128'(orc[d]), 128'(m_rc[d]));
        chk("overflow", d, 128'(oovf[d]), 128'(m_ovf[d]));
        chk("out_valid", d, 128'(ov[d]), 128'(exp_valid));
        if (exp_valid) chk("head_entry", d, 128'(head_bus(d)), 128'(m_buf[d][0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                          input logic [4:0] rd, input logic [31:0] wd);
        ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_we = we; ret_rd = rd; ret_wdata = wd;
        step();
        ret_valid = 1'b0;
    endtask

    logic [31:0]   first_pc [2], first_ins [2], last_pc [2], last_ins [2];
    logic          last_we  [2];
    logic [4:0]    last_rd  [2];
    int            pops     [2];
    logic [EW-1:0] prev_out;
    bit            stalled;
    int            x1, x2;

    initial begin
        reset_n = 1'b0; arm = 1'b0; ret_valid = 1'b0; ret_we = 1'b0; out_ready = 1'b0;
        halt_pc = 32'h14; ret_pc = '0; ret_instr = '0; ret_rd = '0; ret_wdata = '0;
        for (int d = 0; d < 2; d++) begin m_clear(d); m_st[d] = 0; pops[d] = 0; end

        step(); step();
        #2 reset_n = 1'b1;
        step();

        // sum program, halt at 0x14
        arm = 1'b1; step(); arm = 1'b0;
        x1 = 5; x2 = 0;
        retire(32'h00, 32'h00500093, 1'b1, 5'd1, 32'd5);
        retire(32'h04, 32'h00000113, 1'b1, 5'd2, 32'd0);
        for (int k = 0; k < 5; k++) begin
            x2 = x2 + x1;
            retire(32'h08, 32'h00110133, 1'b1, 5'd2, 32'(x2));
            x1 = x1 - 1;
            retire(32'h0c, 32'hfff08093, 1'b1, 5'd1, 32'(x1));
            retire(32'h10, 32'hfe009ce3, 1'b0, 5'd0, 32'd0);
        end
        retire(32'h14, 32'h00000013, 1'b1, 5'd0, 32'd0);
        chk("wrap_count", 0, 128'(orc[0]), 128'(18));
        chk("wrap_ovf", 0, 128'(oovf[0]), 128'(1));
        chk("wrap_entries", 0, 128'(oent[0]), 128'(16));
        chk("nowrap_count", 1, 128'(orc[1]), 128'(17));
        chk("nowrap_entries", 1, 128'(oent[1]), 128'(16));
        chk("nowrap_state", 1, 128'(ost[1]), 128'(2));

        arm = 1'b1; step(); arm = 1'b0;
        chk("arm_in_drain_state", 0, 128'(ost[0]), 128'(2));
        chk("arm_in_drain_entries", 0, 128'(oent[0]), 128'(16));

        // drain with out_ready alternating
        out_ready = 1'b1;
        for (int c = 0; c < 80 && !(m_st[0] == 3 && m_st[1] == 3); c++) begin
            for (int d = 0; d < 2; d++) begin
                if (ov[d] && out_ready) begin
                    if (pops[d] == 0) begin first_pc[d] = opc[d]; first_ins[d] = oins[d]; end
                    last_pc[d] = opc[d]; last_ins[d] = oins[d]; last_we[d] = owe[d]; last_rd[d] = ord[d];
                    pops[d]++;
                end
            end
            stalled  = ov[0] && !out_ready;
            prev_out = head_bus(0);
            step();
            if (stalled) chk("stall_hold", 0, 128'(head_bus(0)), 128'(prev_out));
            out_ready = ~out_ready;
        end
        chk("drain_done", 0, 128'(ost[0]), 128'(3));
        chk("drain_done", 1, 128'(ost[1]), 128'(3));
        chk("drain_pops", 0, 128'(pops[0]), 128'(16));
        chk("drain_pops", 1, 128'(pops[1]), 128'(16));
        chk("first_pc", 0, 128'(first_pc[0]), 128'(32'h08));
        chk("first_instr", 0, 128'(first_ins[0]), 128'(32'h00110133));
        chk("last_pc", 0, 128'(last_pc[0]), 128'(32'h14));
        chk("last_instr", 0, 128'(last_ins[0]), 128'(32'h00000013));
        chk("x0_we", 0, 128'(last_we[0]), 128'(0));
        chk("x0_rd", 0, 128'(last_rd[0]), 128'(0));
        chk("last_pc", 1, 128'(last_pc[1]), 128'(32'h0c));
        chk("last_instr", 1, 128'(last_ins[1]), 128'(32'hfff08093));

        // re-arm from DONE, then restart mid-capture
        out_ready = 1'b0; halt_pc = 32'h40;
        arm = 1'b1; step(); arm = 1'b0;
        for (int k = 0; k < 3; k++) retire(32'h100 + 32'(4 * k), $urandom, 1'b1, 5'd3, $urandom);
        arm = 1'b1; step(); arm = 1'b0;
        chk("restart_entries", 0, 128'(oent[0]), 128'(0));
        chk("restart_count", 0, 128'(orc[0]), 128'(0));

        // asynchronous reset in the middle of a drain
        retire(32'h30, $urandom, 1'b1, 5'd4, $urandom);
        retire(32'h34, $urandom, 1'b1, 5'd5, $urandom);
        retire(32'h38, $urandom, 1'b0, 5'd6, $urandom);
        retire(32'h40, $urandom, 1'b1, 5'd7, $urandom);
        out_ready = 1'b1; step(); step();
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin m_clear(d); m_st[d] = 0; end
        #1;
        check_dut(0); check_dut(1);
        chk("reset_state", 0, 128'(ost[0]), 128'(0));
        chk("reset_out_valid", 0, 128'(ov[0]), 128'(0));
        step();
        reset_n = 1'b1;
        arm = 1'b1; step(); arm = 1'b0;
        retire(32'h44, $urandom, 1'b1, 5'd8, $urandom);
        chk("post_reset_count", 0, 128'(orc[0]), 128'(1));
        chk("post_reset_entries", 1, 128'(oent[1]), 128'(1));

        // randomized traffic against the model
        halt_pc = 32'h20;
        for (int c = 0; c < 600; c++) begin
            ret_valid = 1'($urandom_range(0, 1));
            ret_pc    = 32'($urandom_range(0, 15) * 4);
            ret_instr = $urandom;
            ret_we    = 1'($urandom_range(0, 1));
            ret_rd    = 5'($urandom_range(0, 3));
            ret_wdata = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            arm       = ($urandom_range(0, 24) == 0);
            step();
        end
        arm = 1'b0; ret_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
